// File: rtl/hcs_ctrl_pkg.sv
// Shared state encodings and default timing constants for the health session controller.
package hcs_ctrl_pkg;

   localparam int unsigned STATE_W              = 3;
   localparam int unsigned CONFIRM_TIMEOUT_DEF = 16;
   localparam int unsigned CHECK_CYCLES_DEF    = 2;
   localparam int unsigned ENC_TIMEOUT_DEF     = 32;

   typedef enum logic [STATE_W-1:0] {
      StIdle        = 3'd0,
      StWaitConfirm = 3'd1,
      StSample      = 3'd2,
      StCheck       = 3'd3,
      StEncrypt     = 3'd4,
      StDone        = 3'd5,
      StError       = 3'd6
   } state_e;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/health_session_controller_if.sv
// Operator/datapath signal bundle of the session controller; the controller is the slave side.
interface health_session_controller_if;
   import hcs_ctrl_pkg::*;

   logic               request;
   logic               confirm;
   logic               inputdata;
   logic               abnormalFlag;
   logic               encDone;
   logic               sampleEn;
   logic               checkEn;
   logic               encStart;
   logic               outValid;
   logic               warnLatch;
   logic               timeoutErr;
   logic               busy;
   logic [STATE_W-1:0] state;

   modport master (
      output request, confirm, inputdata, abnormalFlag, encDone,
      input  sampleEn, checkEn, encStart, outValid, warnLatch, timeoutErr, busy, state
   );

   modport slave (
      input  request, confirm, inputdata, abnormalFlag, encDone,
      output sampleEn, checkEn, encStart, outValid, warnLatch, timeoutErr, busy, state
   );

endinterface

// File: rtl/hcs_timeout_counter.sv
// Saturating cycle counter with clear/enable; o_expired is high while the count equals the limit.
module hcs_timeout_counter #(
   parameter int unsigned CNT_W = 6
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic [CNT_W-1:0] i_limit,
   output logic             o_expired
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_expired) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_expired = (r_count == i_limit);

endmodule

// File: rtl/health_session_controller.sv
// Session sequencer: request/confirm handshake, sample strobe, check window, encryption hand-off,
// timeouts and sticky status flags. All outputs are registered.
module health_session_controller
   import hcs_ctrl_pkg::*;
#(
   parameter int unsigned CONFIRM_TIMEOUT = CONFIRM_TIMEOUT_DEF,
   parameter int unsigned CHECK_CYCLES    = CHECK_CYCLES_DEF,
   parameter int unsigned ENC_TIMEOUT     = ENC_TIMEOUT_DEF
) (
   input logic                        clock,
   input logic                        resetn,
   health_session_controller_if.slave bus
);

   localparam int unsigned CNT_W =
      $clog2(max2(max2(CONFIRM_TIMEOUT, ENC_TIMEOUT), CHECK_CYCLES)) + 1;
   localparam logic [CNT_W-1:0] LIM_CONFIRM = CNT_W'(CONFIRM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LIM_CHECK   = CNT_W'(CHECK_CYCLES - 1);
   localparam logic [CNT_W-1:0] LIM_ENC     = CNT_W'(ENC_TIMEOUT - 1);

   state_e           r_state;
   logic             r_req_d;
   logic             r_sample_en;
   logic             r_check_en;
   logic             r_enc_start;
   logic             r_out_valid;
   logic             r_warn;
   logic             r_timeout;
   logic             r_busy;

   logic             w_req_edge;
   logic             w_expired;
   logic             w_stay;
   logic [CNT_W-1:0] w_limit;

   assign w_req_edge = bus.request & ~r_req_d;

   always_comb begin
      w_limit = '0;
      case (r_state)
         StWaitConfirm: w_limit = LIM_CONFIRM;
         StCheck:       w_limit = LIM_CHECK;
         StEncrypt:     w_limit = LIM_ENC;
         default:       w_limit = '0;
      endcase
   end

   // Counter keeps running only while the state will not change; any transition clears it.
   always_comb begin
      w_stay = 1'b0;
      case (r_state)
         StWaitConfirm: w_stay = ~bus.confirm & ~w_expired;
         StCheck:       w_stay = ~w_expired;
         StEncrypt:     w_stay = ~bus.encDone & ~w_expired;
         default:       w_stay = 1'b0;
      endcase
   end

   hcs_timeout_counter #(
      .CNT_W (CNT_W)
   ) u_timeout_counter (
      .clock     (clock),
      .resetn    (resetn),
      .i_clear   (~w_stay),
      .i_enable  (w_stay),
      .i_limit   (w_limit),
      .o_expired (w_expired)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state     <= StIdle;
         r_req_d     <= 1'b0;
         r_sample_en <= 1'b0;
         r_check_en  <= 1'b0;
         r_enc_start <= 1'b0;
         r_out_valid <= 1'b0;
         r_warn      <= 1'b0;
         r_timeout   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_req_d     <= bus.request;
         r_sample_en <= 1'b0;
         r_check_en  <= 1'b0;
         r_enc_start <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_req_edge) begin
                  r_state     <= StWaitConfirm;
                  r_busy      <= 1'b1;
                  r_out_valid <= 1'b0;
                  r_warn      <= 1'b0;
                  r_timeout   <= 1'b0;
               end
            end
            StWaitConfirm: begin
               if (bus.confirm) begin
                  r_state     <= StSample;
                  r_sample_en <= 1'b1;
               end else if (w_expired) begin
                  r_state <= StError;
               end
            end
            StSample: begin
               r_state    <= StCheck;
               r_check_en <= 1'b1;
            end
            StCheck: begin
               r_warn <= r_warn | bus.abnormalFlag;
               if (w_expired) begin
                  if (bus.inputdata) begin
                     r_state     <= StEncrypt;
                     r_enc_start <= 1'b1;
                  end else begin
                     r_state <= StDone;
                  end
               end else begin
                  r_check_en <= 1'b1;
               end
            end
            StEncrypt: begin
               if (bus.encDone) begin
                  r_state     <= StDone;
                  r_out_valid <= 1'b1;
               end else if (w_expired) begin
                  r_state <= StError;
               end
            end
            StDone: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
            StError: begin
               r_timeout <= 1'b1;
               r_state   <= StIdle;
               r_busy    <= 1'b0;
            end
            default: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.sampleEn   = r_sample_en;
   assign bus.checkEn    = r_check_en;
   assign bus.encStart   = r_enc_start;
   assign bus.outValid   = r_out_valid;
   assign bus.warnLatch  = r_warn;
   assign bus.timeoutErr = r_timeout;
   assign bus.busy       = r_busy;
   assign bus.state      = r_state;

endmodule

// File: tb/tb_health_session_controller.sv
// Directed self-checking bench for health_session_controller at default parameters.
module tb_health_session_controller;

   logic clock;
   logic resetn;
   int   n_tests;
   int   n_fail;

   health_session_controller_if bus ();

   health_session_controller dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #30 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Request edge, immediate confirm, then through the check window; ends on the ENCRYPT
   // entry cycle (data=1) or the DONE cycle (data=0).
   task automatic start_session(input logic data);
      bus.inputdata = data;
      bus.request   = 1'b1;
      tick();
      bus.request   = 1'b0;
      bus.confirm   = 1'b1;
      tick();
      bus.confirm   = 1'b0;
      tick();
      tick();
      tick();
   endtask

   task automatic test_reset();
      resetn           = 1'b0;
      bus.request      = 1'b0;
      bus.confirm      = 1'b0;
      bus.inputdata    = 1'b0;
      bus.abnormalFlag = 1'b0;
      bus.encDone      = 1'b0;
      tick();
      tick();
      n_tests++;
      if (bus.state !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_state got=%0d exp=0", bus.state);
      end
      n_tests++;
      if ({bus.sampleEn, bus.checkEn, bus.encStart, bus.outValid, bus.warnLatch,
           bus.timeoutErr, bus.busy} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%b exp=0000000", {bus.sampleEn, bus.checkEn,
                  bus.encStart, bus.outValid, bus.warnLatch, bus.timeoutErr, bus.busy});
      end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_happy_path();
      bus.inputdata = 1'b1;
      bus.request   = 1'b1;
      tick();
      bus.request = 1'b0;
      n_tests++;
      if (bus.state !== 3'd1 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL happy_wait got state=%0d busy=%b exp state=1 busy=1", bus.state, bus.busy);
      end
      tick();
      tick();
      bus.confirm = 1'b1;
      tick();
      bus.confirm = 1'b0;
      n_tests++;
      if (bus.state !== 3'd2 || bus.sampleEn !== 1'b1) begin
         n_fail++;
         $display("FAIL happy_sample got state=%0d sampleEn=%b exp 2/1", bus.state, bus.sampleEn);
      end
      tick();
      n_tests++;
      if (bus.state !== 3'd3 || bus.checkEn !== 1'b1 || bus.sampleEn !== 1'b0) begin
         n_fail++;
         $display("FAIL happy_check1 got state=%0d checkEn=%b sampleEn=%b exp 3/1/0",
                  bus.state, bus.checkEn, bus.sampleEn);
      end
      tick();
      n_tests++;
      if (bus.state !== 3'd3 || bus.checkEn !== 1'b1) begin
         n_fail++;
         $display("FAIL happy_check2 got state=%0d checkEn=%b exp 3/1", bus.state, bus.checkEn);
      end
      tick();
      n_tests++;
      if (bus.state !== 3'd4 || bus.encStart !== 1'b1 || bus.checkEn !== 1'b0) begin
         n_fail++;
         $display("FAIL happy_encstart got state=%0d encStart=%b checkEn=%b exp 4/1/0",
                  bus.state, bus.encStart, bus.checkEn);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++;
         if (bus.state !== 3'd4 || bus.encStart !== 1'b0) begin
            n_fail++;
            $display("FAIL happy_enc_wait%0d got state=%0d encStart=%b exp 4/0",
                     i, bus.state, bus.encStart);
         end
      end
      bus.encDone = 1'b1;
      tick();
      bus.encDone = 1'b0;
      n_tests++;
      if (bus.state !== 3'd5 || bus.outValid !== 1'b1) begin
         n_fail++;
         $display("FAIL happy_done got state=%0d outValid=%b exp 5/1", bus.state, bus.outValid);
      end
      tick();
      n_tests++;
      if (bus.state !== 3'd0 || bus.busy !== 1'b0 || bus.outValid !== 1'b1) begin
         n_fail++;
         $display("FAIL happy_idle got state=%0d busy=%b outValid=%b exp 0/0/1",
                  bus.state, bus.busy, bus.outValid);
      end
   endtask

   task automatic test_confirm_timeout();
      int sample_seen;
      sample_seen   = 0;
      bus.inputdata = 1'b0;
      bus.request   = 1'b1;
      tick();
      bus.request = 1'b0;
      n_tests++;
      if (bus.outValid !== 1'b0) begin
         n_fail++;
         $display("FAIL to_clear_outvalid got=%b exp=0", bus.outValid);
      end
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.sampleEn === 1'b1) sample_seen++;
      end
      n_tests++;
      if (bus.state !== 3'd1) begin
         n_fail++;
         $display("FAIL to_still_waiting got state=%0d exp=1", bus.state);
      end
      tick();
      if (bus.sampleEn === 1'b1) sample_seen++;
      n_tests++;
      if (bus.state !== 3'd6) begin
         n_fail++;
         $display("FAIL to_error got state=%0d exp=6", bus.state);
      end
      tick();
      if (bus.sampleEn === 1'b1) sample_seen++;
      n_tests++;
      if (bus.state !== 3'd0 || bus.timeoutErr !== 1'b1 || bus.busy !== 1'b0 || sample_seen != 0) begin
         n_fail++;
         $display("FAIL to_flag got state=%0d timeoutErr=%b busy=%b samples=%0d exp 0/1/0/0",
                  bus.state, bus.timeoutErr, bus.busy, sample_seen);
      end
      bus.request = 1'b1;
      tick();
      bus.request = 1'b0;
      n_tests++;
      if (bus.timeoutErr !== 1'b0 || bus.state !== 3'd1) begin
         n_fail++;
         $display("FAIL to_clear got timeoutErr=%b state=%0d exp 0/1", bus.timeoutErr, bus.state);
      end
      for (int i = 0; i < 15; i++) tick();
      bus.confirm = 1'b1;
      tick();
      bus.confirm = 1'b0;
      n_tests++;
      if (bus.state !== 3'd2 || bus.sampleEn !== 1'b1) begin
         n_fail++;
         $display("FAIL to_last_confirm got state=%0d sampleEn=%b exp 2/1", bus.state, bus.sampleEn);
      end
      for (int i = 0; i < 4; i++) tick();
      n_tests++;
      if (bus.state !== 3'd0 || bus.outValid !== 1'b0 || bus.timeoutErr !== 1'b0) begin
         n_fail++;
         $display("FAIL to_skip_enc got state=%0d outValid=%b timeoutErr=%b exp 0/0/0",
                  bus.state, bus.outValid, bus.timeoutErr);
      end
   endtask

   task automatic test_abnormality();
      bus.inputdata = 1'b0;
      bus.request   = 1'b1;
      tick();
      bus.request = 1'b0;
      bus.confirm = 1'b1;
      tick();
      bus.confirm = 1'b0;
      tick();
      tick();
      n_tests++;
      if (bus.state !== 3'd3 || bus.warnLatch !== 1'b0) begin
         n_fail++;
         $display("FAIL ab_first_check got state=%0d warn=%b exp 3/0", bus.state, bus.warnLatch);
      end
      bus.abnormalFlag = 1'b1;
      tick();
      bus.abnormalFlag = 1'b0;
      n_tests++;
      if (bus.state !== 3'd5 || bus.warnLatch !== 1'b1 || bus.encStart !== 1'b0) begin
         n_fail++;
         $display("FAIL ab_done got state=%0d warn=%b encStart=%b exp 5/1/0",
                  bus.state, bus.warnLatch, bus.encStart);
      end
      tick();
      n_tests++;
      if (bus.state !== 3'd0 || bus.warnLatch !== 1'b1 || bus.outValid !== 1'b0) begin
         n_fail++;
         $display("FAIL ab_idle got state=%0d warn=%b outValid=%b exp 0/1/0",
                  bus.state, bus.warnLatch, bus.outValid);
      end
      bus.request = 1'b1;
      tick();
      bus.request = 1'b0;
      n_tests++;
      if (bus.warnLatch !== 1'b0) begin
         n_fail++;
         $display("FAIL ab_clear got warn=%b exp=0", bus.warnLatch);
      end
      // Let this session run out via the confirm timeout.
      for (int i = 0; i < 17; i++) tick();
      n_tests++;
      if (bus.state !== 3'd0 || bus.timeoutErr !== 1'b1) begin
         n_fail++;
         $display("FAIL ab_drain got state=%0d timeoutErr=%b exp 0/1", bus.state, bus.timeoutErr);
      end
   endtask

   task automatic test_enc_watchdog();
      start_session(1'b1);
      n_tests++;
      if (bus.state !== 3'd4 || bus.encStart !== 1'b1) begin
         n_fail++;
         $display("FAIL wd_enter got state=%0d encStart=%b exp 4/1", bus.state, bus.encStart);
      end
      for (int i = 0; i < 31; i++) tick();
      n_tests++;
      if (bus.state !== 3'd4) begin
         n_fail++;
         $display("FAIL wd_still_enc got state=%0d exp=4", bus.state);
      end
      tick();
      n_tests++;
      if (bus.state !== 3'd6) begin
         n_fail++;
         $display("FAIL wd_error got state=%0d exp=6", bus.state);
      end
      tick();
      n_tests++;
      if (bus.state !== 3'd0 || bus.timeoutErr !== 1'b1 || bus.outValid !== 1'b0) begin
         n_fail++;
         $display("FAIL wd_flag got state=%0d timeoutErr=%b outValid=%b exp 0/1/0",
                  bus.state, bus.timeoutErr, bus.outValid);
      end
      start_session(1'b1);
      bus.encDone = 1'b1;
      tick();
      bus.encDone = 1'b0;
      n_tests++;
      if (bus.state !== 3'd5 || bus.outValid !== 1'b1 || bus.timeoutErr !== 1'b0) begin
         n_fail++;
         $display("FAIL wd_fast_done got state=%0d outValid=%b timeoutErr=%b exp 5/1/0",
                  bus.state, bus.outValid, bus.timeoutErr);
      end
      tick();
   endtask

   task automatic test_ignored_requests();
      int starts;
      starts        = 0;
      bus.inputdata = 1'b0;
      bus.request   = 1'b1;
      tick();
      if (bus.busy === 1'b1) starts++;
      for (int i = 0; i < 3; i++) begin
         bus.request = 1'b0;
         tick();
         bus.request = 1'b1;
         tick();
      end
      bus.request = 1'b0;
      bus.confirm = 1'b1;
      tick();
      bus.confirm = 1'b0;
      n_tests++;
      if (bus.state !== 3'd2) begin
         n_fail++;
         $display("FAIL ign_sample got state=%0d exp=2", bus.state);
      end
      for (int i = 0; i < 8; i++) begin
         logic prev_busy;
         prev_busy = bus.busy;
         tick();
         if (bus.busy === 1'b1 && prev_busy === 1'b0) starts++;
      end
      n_tests++;
      if (starts != 1 || bus.state !== 3'd0) begin
         n_fail++;
         $display("FAIL ign_toggle got sessions=%0d state=%0d exp 1/0", starts, bus.state);
      end
      bus.request = 1'b1;
      start_session(1'b0);
      bus.request = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_held%0d got busy=%b exp=0", i, bus.busy);
         end
      end
      bus.request = 1'b0;
      tick();
      bus.request = 1'b1;
      tick();
      bus.request = 1'b0;
      n_tests++;
      if (bus.busy !== 1'b1 || bus.state !== 3'd1) begin
         n_fail++;
         $display("FAIL ign_reedge got busy=%b state=%0d exp 1/1", bus.busy, bus.state);
      end
      bus.confirm = 1'b1;
      tick();
      bus.confirm = 1'b0;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_reset_mid();
      start_session(1'b1);
      tick();
      tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      n_tests++;
      if (bus.state !== 3'd0 || {bus.sampleEn, bus.checkEn, bus.encStart, bus.outValid,
          bus.warnLatch, bus.timeoutErr, bus.busy} !== 7'b0) begin
         n_fail++;
         $display("FAIL rst_mid got state=%0d outs=%b exp 0/0000000", bus.state,
                  {bus.sampleEn, bus.checkEn, bus.encStart, bus.outValid, bus.warnLatch,
                   bus.timeoutErr, bus.busy});
      end
      bus.encDone = 1'b1;
      tick();
      tick();
      bus.encDone = 1'b0;
      n_tests++;
      if (bus.state !== 3'd0 || bus.outValid !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_encdone_ignored got state=%0d outValid=%b busy=%b exp 0/0/0",
                  bus.state, bus.outValid, bus.busy);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_happy_path();
      test_confirm_timeout();
      test_abnormality();
      test_enc_watchdog();
      test_ignored_requests();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
